rob_ctrl: RTL
=============

ROB_CTRL -- requirements
Module: rob_ctrl

Interface
REQ-001 SHALL have parameter ROB_SZ, default 8, number of reorder-buffer entries.
REQ-002 SHALL have parameter TAG_W, default 4, ROB tag width; tags 1..ROB_SZ valid, tag 0 = "no tag".
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 dispatch_valid  input  1  dispatch request this cycle.
REQ-006 dispatch_has_dest, dispatch_dest_reg  input  1, 5  destination present; architectural dest index.
REQ-007 cdb_valid, cdb_rob_tag, cdb_value  input  1, TAG_W, 32  completion broadcast.
REQ-008 branch_valid, branch_rob_tag  input  1, TAG_W  mispredicted branch; squash all entries younger than it.
REQ-009 rob_full  output  1  no free entry; dispatch stalls.
REQ-010 rob_new_tail_tag  output  TAG_W  tag given to an instruction dispatched this cycle.
REQ-011 tail  output  TAG_W  tag of youngest allocated entry (predecessor of rob_new_tail_tag).
REQ-012 retire_valid, retire_rob_tag  output  1, TAG_W  head entry retiring this cycle.
REQ-013 retire_has_dest, retire_dest_reg, retire_value  output  1, 5, 32  retiring entry's destination and result.
REQ-014 count  output  TAG_W  number of occupied entries, 0..ROB_SZ.

Function
REQ-015 Entries SHALL form a circular buffer indexed by tag; successor of ROB_SZ is 1; tag 0 is never allocated.
REQ-016 Each entry SHALL hold valid, complete, has_dest, dest_reg, value.
REQ-017 rob_new_tail_tag SHALL equal successor(tail), combinational.
REQ-018 rob_full SHALL be 1 iff count == ROB_SZ; a same-cycle retire SHALL NOT unblock dispatch.
REQ-019 Dispatch accepted iff dispatch_valid && !rob_full && !branch_valid; on accept the entry at rob_new_tail_tag becomes valid, incomplete, fields captured, and tail advances at the next edge.
REQ-020 cdb_valid with a tag naming a valid entry SHALL set complete and store cdb_value at the edge; tag 0, invalid entries, or entries squashed the same cycle SHALL be ignored.
REQ-021 retire_valid SHALL be 1 iff head entry is valid and complete (registered state); outputs SHALL reflect the head entry; the head entry is freed and head advances at the edge. At most one retire per cycle.
REQ-022 branch_valid SHALL invalidate every valid entry strictly younger than branch_rob_tag (circular order from successor(branch_rob_tag) to tail), set tail = branch_rob_tag, and recompute count; branch entry itself is kept.
REQ-023 Squash SHALL take priority over dispatch in the same cycle; retire of the head proceeds in the same cycle as a squash, including when head == branch_rob_tag.
REQ-024 branch_valid naming an invalid entry SHALL cause no state change.
REQ-025 count SHALL update as count + accepted_dispatch - retire, or post-squash occupancy minus retire when squashing.

Reset
REQ-026 On reset: head = 1, tail = ROB_SZ, count = 0, all entries invalid and incomplete, values 0.
REQ-027 Outputs during/after reset: rob_full = 0, rob_new_tail_tag = 1, tail = ROB_SZ, retire_valid = 0, retire_rob_tag = 0, retire_has_dest = 0, retire_dest_reg = 0, retire_value = 0, count = 0.
REQ-028 Reset SHALL override dispatch, cdb, and branch inputs in the same cycle.

Configuration
REQ-029 Macro ROB_CDB_RETIRE_BYPASS_EN: defined -> a valid incomplete head matched by cdb_valid/cdb_rob_tag this cycle SHALL retire this cycle with retire_value = cdb_value; undefined -> such head retires no earlier than the following cycle.

Verification
REQ-030 Reset, dispatch 3 (tags 1,2,3), cdb tag 2 value 0x22, then cdb tag 1 value 0x11 -> retire tag 1 (0x11) the cycle after, tag 2 (0x22) the next cycle, count = 1.
REQ-031 Dispatch 8 -> rob_full = 1, 9th dispatch ignored; complete and retire tag 1 -> next cycle rob_full = 0, next dispatch receives tag 1 (wrap).
REQ-032 Dispatch tags 1..5, branch_valid tag 2 -> tail = 2, count = 2, next dispatch receives tag 3; later cdb tag 4 leaves no complete entry beyond tag 2.
REQ-033 branch_valid and dispatch_valid same cycle -> dispatch ignored, count unchanged by dispatch.
REQ-034 Wrap squash: head = 7, entries 7,8,1,2 valid; branch tag 8 -> tail = 8, count = 2, rob_new_tail_tag = 1.
REQ-035 Head tag 1 incomplete, cdb tag 1 value 0xAB -> with ROB_CDB_RETIRE_BYPASS_EN retire_valid = 1, retire_value = 0xAB same cycle; without, retire_valid = 1 next cycle.

Source files
------------

// File: rtl/rob_ctrl.sv
// rob_ctrl -- reorder-buffer bookkeeping controller.
//
// Keeps ROB_SZ entries in a circular buffer addressed by tag (1..ROB_SZ,
// tag 0 means "no tag"). Allocates in order at dispatch, marks entries
// complete from the CDB, retires the head in order (one per cycle) and
// squashes everything younger than a mispredicted branch.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   dispatch_valid/has_dest/dest_reg  allocation request and its destination
//   cdb_valid/cdb_rob_tag/cdb_value   completion broadcast
//   branch_valid/branch_rob_tag       mispredict: squash entries younger than tag
//   rob_full, rob_new_tail_tag, tail, count   occupancy and allocation status
//   retire_valid/rob_tag/has_dest/dest_reg/value  head entry retiring this cycle
//
// Build option: define ROB_CDB_RETIRE_BYPASS_EN to let an incomplete head
// retire in the same cycle its CDB result arrives (value taken from the CDB).
// Without it the head retires no earlier than the cycle after completion.
module rob_ctrl #(
  parameter int ROB_SZ = 8,
  parameter int TAG_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dispatch_valid,
  input  logic             dispatch_has_dest,
  input  logic [4:0]       dispatch_dest_reg,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_rob_tag,
  input  logic [31:0]      cdb_value,
  input  logic             branch_valid,
  input  logic [TAG_W-1:0] branch_rob_tag,
  output logic             rob_full,
  output logic [TAG_W-1:0] rob_new_tail_tag,
  output logic [TAG_W-1:0] tail,
  output logic             retire_valid,
  output logic [TAG_W-1:0] retire_rob_tag,
  output logic             retire_has_dest,
  output logic [4:0]       retire_dest_reg,
  output logic [31:0]      retire_value,
  output logic [TAG_W-1:0] count
);

  localparam logic [TAG_W-1:0] SZ  = TAG_W'(ROB_SZ);
  localparam logic [TAG_W-1:0] ONE = TAG_W'(1);

  function automatic logic [TAG_W-1:0] succ(input logic [TAG_W-1:0] t);
    return (t == SZ) ? ONE : t + ONE;
  endfunction

  // Position of tag t counted from the head (0 = oldest). Arithmetic wraps
  // modulo 2**TAG_W, which is harmless because the true result is < ROB_SZ.
  function automatic logic [TAG_W-1:0] age(input logic [TAG_W-1:0] from,
                                            input logic [TAG_W-1:0] t);
    return (t >= from) ? t - from : t + SZ - from;
  endfunction

  logic        ent_valid    [ROB_SZ];
  logic        ent_complete [ROB_SZ];
  logic        ent_has_dest [ROB_SZ];
  logic [4:0]  ent_dest     [ROB_SZ];
  logic [31:0] ent_value    [ROB_SZ];

  logic [TAG_W-1:0] head;
  logic             h_valid, h_complete, h_has_dest;
  logic [4:0]       h_dest;
  logic [31:0]      h_value;
  logic             br_hit, squash, do_retire, do_dispatch;
  logic [31:0]      ret_value;
  logic [TAG_W-1:0] keep_cnt;

  always_comb begin
    h_valid    = 1'b0;
    h_complete = 1'b0;
    h_has_dest = 1'b0;
    h_dest     = '0;
    h_value    = '0;
    br_hit     = 1'b0;
    for (int i = 0; i < ROB_SZ; i++) begin
      if (TAG_W'(i + 1) == head) begin
        h_valid    = ent_valid[i];
        h_complete = ent_complete[i];
        h_has_dest = ent_has_dest[i];
        h_dest     = ent_dest[i];
        h_value    = ent_value[i];
      end
      if (TAG_W'(i + 1) == branch_rob_tag && ent_valid[i])
        br_hit = 1'b1;
    end
    // A branch naming a free entry (or tag 0) is stale and does nothing.
    squash = branch_valid && br_hit;
`ifdef ROB_CDB_RETIRE_BYPASS_EN
    do_retire = !reset && h_valid &&
                (h_complete || (cdb_valid && cdb_rob_tag == head));
    ret_value = h_complete ? h_value : cdb_value;
`else
    do_retire = !reset && h_valid && h_complete;
    ret_value = h_value;
`endif
    do_dispatch = dispatch_valid && !rob_full && !branch_valid;
    // Entries kept by a squash: head through the branch entry inclusive.
    keep_cnt = age(head, branch_rob_tag) + ONE;
  end

  assign rob_full         = (count == SZ);
  assign rob_new_tail_tag = succ(tail);
  assign retire_valid     = do_retire;
  assign retire_rob_tag   = do_retire ? head : '0;
  assign retire_has_dest  = do_retire ? h_has_dest : 1'b0;
  assign retire_dest_reg  = do_retire ? h_dest : '0;
  assign retire_value     = do_retire ? ret_value : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= ONE;
      tail  <= SZ;
      count <= '0;
      for (int i = 0; i < ROB_SZ; i++) begin
        ent_valid[i]    <= 1'b0;
        ent_complete[i] <= 1'b0;
        ent_has_dest[i] <= 1'b0;
        ent_dest[i]     <= '0;
        ent_value[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < ROB_SZ; i++) begin
        // Squash and dispatch never coincide (branch_valid blocks dispatch).
        // A squashed or retiring entry ignores any CDB write this cycle.
        if (squash && ent_valid[i] &&
            age(head, TAG_W'(i + 1)) > age(head, branch_rob_tag)) begin
          ent_valid[i]    <= 1'b0;
          ent_complete[i] <= 1'b0;
        end else if (do_retire && TAG_W'(i + 1) == head) begin
          ent_valid[i]    <= 1'b0;
          ent_complete[i] <= 1'b0;
        end else if (do_dispatch && TAG_W'(i + 1) == rob_new_tail_tag) begin
          ent_valid[i]    <= 1'b1;
          ent_complete[i] <= 1'b0;
          ent_has_dest[i] <= dispatch_has_dest;
          ent_dest[i]     <= dispatch_dest_reg;
          ent_value[i]    <= '0;
        end else if (cdb_valid && ent_valid[i] && TAG_W'(i + 1) == cdb_rob_tag) begin
          ent_complete[i] <= 1'b1;
          ent_value[i]    <= cdb_value;
        end
      end

      if (do_retire)
        head <= succ(head);

      if (squash) begin
        tail  <= branch_rob_tag;
        count <= keep_cnt - TAG_W'(do_retire);
      end else begin
        if (do_dispatch)
          tail <= rob_new_tail_tag;
        count <= count + TAG_W'(do_dispatch) - TAG_W'(do_retire);
      end
    end
  end

endmodule
